// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Minimum number of decimal digits d such that 10^d > 2^width - 1.
    function automatic int unsigned bcd_digits(input int unsigned width);
        longint unsigned limit;
        longint unsigned pow10;
        int unsigned     d;
        limit = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        pow10 = 64'd1;
        d     = 0;
        while ((pow10 <= limit) && (d < 20)) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: a nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [NIBBLE_W-1:0] nibble_o
);

    // Add 3 within the nibble; no carry leaves the digit.
    always_comb begin
        nibble_o = nibble_i;
        if (nibble_i >= 4'd5) begin
            nibble_o = nibble_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Holds the last result on out_bcd and flags each new result with a one-cycle done.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned DIGITS   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_WIDTH-1:0]          in_data,
    output logic                         done,
    output logic [NIBBLE_W*DIGITS-1:0]   out_bcd
);

    localparam int unsigned BCD_W = NIBBLE_W * DIGITS;
    localparam int unsigned CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

    if (DIGITS < bcd_digits(IN_WIDTH)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS=%0d too small for IN_WIDTH=%0d (need %0d)",
               DIGITS, IN_WIDTH, bcd_digits(IN_WIDTH));
    end

    state_t              state_q,   state_d;
    logic [IN_WIDTH-1:0] bin_q,     bin_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [BCD_W-1:0]    out_q,     out_d;
    logic                done_q,    done_d;

    logic [BCD_W-1:0]    scratch_adj;
    logic [BCD_W-1:0]    scratch_shl;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nibble_i (scratch_q[g*NIBBLE_W +: NIBBLE_W]),
            .nibble_o (scratch_adj[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    // Adjusted scratch shifted left, taking in the next binary MSB.
    always_comb begin
        scratch_shl = {scratch_adj[BCD_W-2:0], bin_q[IN_WIDTH-1]};
    end

    // Next-state, datapath and output decode for the IDLE/SHIFT controller.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bin_d     = in_data;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = scratch_shl;
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_d   = scratch_shl;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign done     = done_q;
    assign out_bcd  = out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (8-bit/3-digit and 16-bit/5-digit builds).
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        v8, v16;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        r8, r16, dn8, dn16;
    logic [11:0] o8;
    logic [19:0] o16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .in_data(d8), .done(dn8), .out_bcd(o8)
    );

    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
        .in_data(d16), .done(dn16), .out_bcd(o16)
    );

    typedef struct {
        logic [7:0]  data;
        logic [11:0] exp;
    } vec_t;

    // Decimal digits by repeated division, packed units-first.
    function automatic logic [19:0] ref_bcd(input int unsigned value);
        logic [19:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_nibble_over9(input logic [19:0] x);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (x[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic convert(input bit wide, input logic [15:0] d, input string nm,
                           input logic [19:0] exp);
        int edges;
        int ready_low;
        int w;
        w = wide ? 16 : 8;
        edges = 0;
        while (!(wide ? r16 : r8) && edges < 40) begin
            step;
            edges++;
        end
        if (wide) begin v16 = 1'b1; d16 = d; end
        else      begin v8  = 1'b1; d8  = d[7:0]; end
        step;
        v8  = 1'b0;
        v16 = 1'b0;
        edges     = 1;
        ready_low = 0;
        while (!(wide ? dn16 : dn8) && edges < 40) begin
            if (!(wide ? r16 : r8)) ready_low++;
            step;
            edges++;
        end
        check({nm, " latency"},    edges, w + 1);
        check({nm, " ready_low"},  ready_low, w);
        check({nm, " result"},     wide ? o16 : {8'h0, o8}, exp);
        check({nm, " nibble<=9"},  any_nibble_over9(wide ? o16 : {8'h0, o8}), 0);
        check({nm, " ready@done"}, wide ? r16 : r8, 1);
        step;
        check({nm, " done 1cyc"},  wide ? dn16 : dn8, 0);
        check({nm, " held"},       wide ? o16 : {8'h0, o8}, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   edges;
        int   pulses;

        vecs[0] = '{8'd255, 12'h255};
        vecs[1] = '{8'd0,   12'h000};
        vecs[2] = '{8'd9,   12'h009};
        vecs[3] = '{8'd99,  12'h099};
        vecs[4] = '{8'd100, 12'h100};
        vecs[5] = '{8'd199, 12'h199};

        rst = 1'b1; v8 = 1'b0; v16 = 1'b0; d8 = '0; d16 = '0;
        repeat (3) step;
        check("rst done",  dn8, 0);
        check("rst out",   o8, 12'h000);
        rst = 1'b0;
        step;
        check("post-rst ready",   r8, 1);
        check("post-rst done",    dn8, 0);
        check("post-rst out",     o8, 12'h000);
        check("post-rst ready16", r16, 1);
        check("post-rst out16",   o16, 20'h0);

        for (int i = 0; i < 6; i++) begin
            convert(1'b0, {8'h0, vecs[i].data}, $sformatf("vec%0d", i), {8'h0, vecs[i].exp});
        end

        for (int i = 0; i < 20; i++) begin
            int unsigned x;
            x = $urandom_range(0, 255);
            convert(1'b0, 16'(x), $sformatf("rnd8_%0d(%0d)", i, x), ref_bcd(x));
        end

        // Back-to-back: valid held high, data changed mid-conversion.
        v8 = 1'b1; d8 = 8'd7;
        step;
        d8 = 8'd200;
        edges = 1;
        while (!dn8 && edges < 40) begin step; edges++; end
        check("b2b first latency", edges, 9);
        check("b2b first result",  o8, 12'h007);
        check("b2b ready@done",    r8, 1);
        step;
        v8 = 1'b0;
        check("b2b accepted done", dn8, 0);
        check("b2b accepted busy", r8, 0);
        edges = 1;
        while (!dn8 && edges < 40) begin step; edges++; end
        check("b2b done spacing", edges, 9);
        check("b2b second result", o8, 12'h200);
        step;
        check("b2b done 1cyc", dn8, 0);

        // Reset on the 4th shift edge of converting 123.
        v8 = 1'b1; d8 = 8'd123;
        step;
        v8 = 1'b0;
        repeat (3) step;
        rst = 1'b1;
        step;
        check("midrst out",   o8, 12'h000);
        check("midrst done",  dn8, 0);
        check("midrst ready", r8, 1);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step;
            if (dn8) pulses++;
        end
        check("midrst no done", pulses, 0);
        check("midrst out held", o8, 12'h000);
        convert(1'b0, 16'd45, "after-rst 45", 20'h00045);

        convert(1'b1, 16'hFFFF, "w65535", 20'h65535);
        convert(1'b1, 16'd0,    "w0",     20'h00000);
        for (int i = 0; i < 6; i++) begin
            int unsigned x;
            x = $urandom_range(0, 65535);
            convert(1'b1, 16'(x), $sformatf("rnd16_%0d(%0d)", i, x), ref_bcd(x));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
Sits between the 8-bit counter and the 4-digit seven-segment driver.
Turns the counter's binary value into decimal digits so the display shows 0..255 in decimal.
Holds the last result stable for the display mux and signals each new result with a one-cycle done pulse.

Parameters:
IN_WIDTH, 8, width of the binary input.
DIGITS, 3, number of BCD output digits. Elaboration requires 10^DIGITS > 2^IN_WIDTH−1; generate-time error otherwise.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  in_data is offered for conversion.
in_ready  output  1  converter idle and able to accept.
in_data  input  IN_WIDTH  unsigned binary value.
done  output  1  one-cycle pulse: out_bcd has just been updated.
out_bcd  output  4*DIGITS  result, digit 0 (units) in bits [3:0], packed upward.

Behaviour:
- Clocking: all state updates on posedge clk; rst is sampled only on posedge clk.
- Reset values: state=IDLE, out_bcd=0, done=0, in_ready=1, internal shift/bcd registers=0, bit counter=0.
- rst has priority over every other event, including mid-conversion. The in-flight conversion is discarded, out_bcd is cleared to 0 and no done pulse is issued.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
- in_ready is decoded from state: high exactly when state==IDLE.
- Accept (edge E0): in_valid & in_ready.
  - Load the binary shift register with in_data; clear the BCD scratch register; counter=0; go to SHIFT.
  - in_data is sampled only at E0; later changes are ignored.
- SHIFT, each edge:
  - Every scratch nibble ≥5 gets +3 (combinational, 4-bit, no carry out of nibble).
  - Then {scratch, binreg} shifts left by 1; counter increments.
- Final edge E_IN_WIDTH (counter==IN_WIDTH−1):
  - Write the adjusted+shifted scratch directly into out_bcd.
  - done=1 for the following cycle only.
  - Go to IDLE.
- Latency: accept at E0 → done visible and out_bcd valid after E_IN_WIDTH. That is IN_WIDTH+1 edges from accept, 9 for the default.
- Throughput: in_ready is high in the done cycle, so a new accept can occur on that same edge. The sustained rate is one conversion per IN_WIDTH+1 cycles.
- in_valid while in SHIFT: ignored, no queuing. The producer holds in_valid until the handshake.
- out_bcd changes only on a final edge or on rst. It is held indefinitely otherwise, so the display never shows partial digits.
- done is a registered output, never asserted in the same cycle as rst=1 takes effect.
- Boundaries:
  - in_data=0 → all digits 0.
  - in_data=2^IN_WIDTH−1 → exact decimal, no overflow by parameter rule.
  - No nibble ever exceeds 9 in out_bcd.

Decomposition:
- Shared package bcd_pkg:
  - state encoding localparams (ST_IDLE, ST_SHIFT);
  - constant function bcd_digits(width) returning the minimum DIGITS, used for the elaboration check;
  - nibble width constant 4.
- One sub-module, bcd_digit_adj: combinational 4-bit "if ≥5 add 3" corrector, instantiated DIGITS times via generate.
- The FSM, counter and registers stay in bin_to_bcd_seq.

Test Plan:
- Reset release → in_ready=1, done=0, out_bcd=0x000 on the first cycle after rst deasserts.
- Accept 8'd255 → done pulses exactly 9 edges after accept, out_bcd=0x255; in_ready=0 for 8 cycles in between.
- Accept 0, then 9, 99, 100, 199 → out_bcd=0x000, 0x009, 0x099, 0x100, 0x199. No nibble >9; done is exactly one cycle each.
- Back-to-back with in_valid held high, data 7 then 200 → second accept on the first done cycle. Results 0x007 then 0x200, done pulses 9 cycles apart; in_valid asserted mid-SHIFT is not accepted.
- rst=1 on the 4th SHIFT edge of converting 123 → out_bcd=0, no done pulse. in_ready=1 next cycle, and a subsequent accept of 45 gives 0x045.
- Param IN_WIDTH=16, DIGITS=5, input 65535 → out_bcd=0x65535 after 17 edges. DIGITS=4 with IN_WIDTH=16 fails elaboration.
